instr_loader: RTL and testbench
===============================

# instr_loader

Program loader for the 8-bit processor's instruction memory. Accepts a byte stream over a valid/ready handshake, packs every four bytes into a 32-bit instruction word, and writes the words into the instruction memory through its write port. The write addresses use the same byte-address stepping (+4) as the program counter. The processor is held off while a load is in progress.

## Interface
Parameters:
- DEPTH, 8, number of 32-bit words in instruction memory; legal word count is 1..DEPTH
- ADDR_W, 32, width of the write address; matches the program counter width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  single-cycle request to begin a load; acted on only in IDLE
- in_valid  in  1  stream byte present
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts in_data this cycle
- wr_en  out  1  instruction memory write strobe, one cycle per word
- wr_addr  out  ADDR_W  byte address of the word being written
- wr_data  out  32  instruction word being written
- cpu_hold  out  1  processor must not fetch while this is high
- done  out  1  one-cycle pulse when a load completes
- err  out  1  sticky header error flag

## Operation
- Transfer: one byte moves on each rising edge where in_valid and in_ready are both high. in_valid may drop at any time; the loader waits.
- Stream format: header byte N (word count), followed by 4·N data bytes, little-endian per word. Byte 0 goes to wr_data[7:0]; byte 3 goes to wr_data[31:24].
- States:
  - IDLE: in_ready=0, cpu_hold=0. start → HDR; clears err, zeroes the address and byte index.
  - HDR: in_ready=1. On header accept: if N==0 or N>DEPTH → ERR; else load the words-left counter with N and go to DATA.
  - DATA: in_ready=1. Accepted bytes fill byte slot idx (2-bit, 0..3). Accepting slot 3 → WRITE.
  - WRITE: in_ready=0, wr_en=1, wr_addr = current address, wr_data = packed word. Then the address advances by 4 and words-left decrements; words-left reaching 0 → DONE, else → DATA with idx=0.
  - DONE: done=1 for one cycle, cpu_hold=0, → IDLE.
  - ERR: err=1, cpu_hold=1, in_ready=0; stays here until start, which → HDR and clears err.
- cpu_hold=1 in HDR, DATA, WRITE and ERR.
- start is ignored in HDR, DATA, WRITE and DONE.
- Bytes presented while in_ready=0 are not consumed. No data flows beyond the N words; trailing bytes wait for the next load.
- The address is masked to ADDR_W. It cannot wrap within a legal load because N ≤ DEPTH.

## Timing
- Reset (reset==0 at a rising edge) takes priority over all other inputs, including mid-load. It forces:
  - state IDLE
  - in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, err=0
  - the partial word is discarded and no write is issued
- All outputs are registered or decoded from registered state; there is no combinational path from in_valid/in_data to any output.
- Latency, with last data byte accepted at edge k:
  - wr_en high in cycle k..k+1
  - next byte can be accepted at edge k+2
  - best-case throughput is 5 cycles per word
- Final word's write cycle is followed by one DONE cycle with done=1. cpu_hold falls at the same edge that raises done.
- Start to first in_ready high: 1 cycle.
- wr_data and wr_addr hold their last written values outside WRITE. Memory must sample only on wr_en.

## Structure
- Shared package instr_loader_pkg:
  - state enum: IDLE, HDR, DATA, WRITE, DONE, ERR
  - BYTES_PER_WORD=4
  - ADDR_STEP=4
- Sub-module byte_packer: a 4×8 shift/slot register with a 2-bit index. Ports: clk, reset, load, clear, byte_in, word_out, last (idx==3).
- The top level holds the FSM, the address register and the words-left counter.

## Test plan
- Reset mid-load: assert reset==0 for 1 cycle after 2 data bytes → all outputs 0, state IDLE, no wr_en. A fresh load of 1 word then writes wr_addr=0.
- Single word: start, stream 01, 03,03,01,01 with in_valid held high → one wr_en pulse, wr_addr=0x0, wr_data=0x01010303; done pulses 1 cycle later and cpu_hold falls with it.
- Full memory with gaps: N=8, words 0x00000000..0x00000007, in_valid deasserted every other cycle → 8 writes at addresses 0,4,…,28 with matching data, no extra or missing strobes, in_ready never high during WRITE.
- Header errors:
  - N=0 → err=1, cpu_hold=1, no writes, in_ready=0 for 20 cycles.
  - Then start with N=9 (DEPTH=8) → err stays 1, no writes.
  - Then start with N=1 → err clears at start, load completes normally.
- Ignored start: pulse start during DATA of a 2-word load → no restart, addresses continue 0 then 4, done pulses once.
- Back-to-back loads: load N=1 word 0xAAAAAAAA, then start immediately after done with N=1 word 0x55555555 → second write at wr_addr=0 with data 0x55555555.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// The FSM encoding is fixed so waveforms and older tools see stable state values.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_STEP      = 4;

  // A header is usable only when it names at least one word and fits the memory.
  function automatic logic header_ok(input logic [7:0] n, input int depth);
    return (n != 8'd0) && (int'(n) <= depth);
  endfunction

endpackage

// File: rtl/instr_loader_packer.sv
// Byte-to-word packer: four byte slots filled in order by a 2-bit index.
// Slot 0 lands in word_out[7:0], so the stream is little-endian per word.
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        last
);

  logic [1:0] idx_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_reg <= 2'd0;
    end else if (clear) begin
      idx_reg <= 2'd0;
    end else if (load) begin
      idx_reg <= idx_reg + 2'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_slot
      logic [7:0] slot_reg;

      always_ff @(posedge clk) begin
        if (!reset) begin
          slot_reg <= 8'd0;
        end else if (load && (idx_reg == 2'(gi))) begin
          slot_reg <= byte_in;
        end
      end

      assign word_out[gi*8 +: 8] = slot_reg;
    end
  endgenerate

  assign last = (idx_reg == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_loader.sv
// Program loader: header byte N, then 4*N bytes packed into words and written
// to instruction memory at byte addresses 0, 4, 8, ... while the CPU is held.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  state_e            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [31:0]       wr_data_reg;
  logic [CNT_W-1:0]  left_reg;
  logic              err_reg;

  logic        start_take;
  logic        hdr_take;
  logic        hdr_good;
  logic        byte_load;
  logic [31:0] word;
  logic        word_last;

  assign start_take = start && ((state_reg == IDLE) || (state_reg == ERR));
  assign hdr_take   = in_valid && (state_reg == HDR);
  assign hdr_good   = header_ok(in_data, DEPTH);
  assign byte_load  = in_valid && (state_reg == DATA);

  byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .load     (byte_load),
    .clear    (start_take),
    .byte_in  (in_data),
    .word_out (word),
    .last     (word_last)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = HDR;
      HDR:     if (in_valid) state_next = hdr_good ? DATA : ERR;
      DATA:    if (in_valid && word_last) state_next = WRITE;
      WRITE:   state_next = (left_reg == CNT_W'(1)) ? DONE : DATA;
      DONE:    state_next = IDLE;
      ERR:     if (start) state_next = HDR;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      left_reg    <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (start_take) begin
        addr_reg <= '0;
        err_reg  <= 1'b0;
      end

      if (hdr_take) begin
        if (hdr_good) begin
          left_reg <= CNT_W'(in_data);
        end else begin
          err_reg <= 1'b1;
        end
      end

      // The write cycle's address/data are kept so the port holds them afterwards.
      if (state_reg == WRITE) begin
        addr_reg    <= addr_reg + ADDR_W'(ADDR_STEP);
        left_reg    <= left_reg - CNT_W'(1);
        wr_addr_reg <= addr_reg;
        wr_data_reg <= word;
      end
    end
  end

  assign in_ready = (state_reg == HDR) || (state_reg == DATA);
  assign wr_en    = (state_reg == WRITE);
  assign wr_addr  = wr_en ? addr_reg : wr_addr_reg;
  assign wr_data  = wr_en ? word : wr_data_reg;
  assign cpu_hold = (state_reg == HDR) || (state_reg == DATA) ||
                    (state_reg == WRITE) || (state_reg == ERR);
  assign done     = (state_reg == DONE);
  assign err      = err_reg;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: loads push expected writes/done pulses,
// a negedge monitor pops and compares whenever the loader strobes.
module tb_instr_loader;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              done;
  logic              err;

  instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          total = 0;
  int          bad = 0;
  wr_t         exp_q[$];
  int          exp_done = 0;
  logic        prev_wr = 1'b0;
  logic [31:0] lw[16];
  bit          alt = 1'b0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe from the DUT must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr=%0h data=%0h with nothing expected", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 72'(wr_addr), 72'(e.addr));
        check("wr_data", 72'(wr_data), 72'(e.data));
        $display("write addr=%0h data=%08h", wr_addr, wr_data);
      end
      check("in_ready_during_write", 72'(in_ready), 72'(0));
    end
    if (done) begin
      if (exp_done == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: done=1 with no load pending");
      end else begin
        exp_done--;
      end
      check("cpu_hold_at_done", 72'(cpu_hold), 72'(0));
      check("done_follows_write", 72'(prev_wr), 72'(1));
    end
    prev_wr <= wr_en;
  end

  task automatic send_byte(input logic [7:0] b, input int mode);
    int waited = 0;
    bit sent = 1'b0;
    while (!sent) begin
      @(negedge clk);
      waited++;
      if (waited > 100) begin
        $display("FAIL send_timeout: byte %02h not accepted within 100 cycles", b);
        $fatal(1, "stream stalled");
      end
      alt = ~alt;
      if ((mode == 1 && alt) || (mode == 2 && $urandom_range(99) < 30)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        sent     = in_ready;
      end
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_clear_on_start", 72'(err), 72'(0));
    check("hold_in_hdr", 72'(cpu_hold), 72'(1));
    check("ready_after_start", 72'(in_ready), 72'(1));
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((exp_q.size() != 0 || exp_done != 0) && c < 200) begin
      @(posedge clk);
      #2;
      c++;
    end
    total++;
    if (exp_q.size() != 0 || exp_done != 0) begin
      bad++;
      $display("FAIL drain: %0d writes and %0d done pulses still pending", exp_q.size(), exp_done);
    end
  endtask

  // Reference: a legal load of n words writes lw[i] at byte address 4*i, then one done.
  task automatic run_load(input int n, input int mode, input int pulse_at);
    bit good;
    good = (n >= 1) && (n <= DEPTH);
    do_start();
    if (good) begin
      for (int i = 0; i < n; i++) exp_q.push_back('{addr: 32'(4 * i), data: lw[i]});
      exp_done++;
    end
    send_byte(8'(n), mode);
    if (good) begin
      for (int w = 0; w < n; w++) begin
        for (int b = 0; b < 4; b++) begin
          if (w * 4 + b == pulse_at) start = 1'b1;
          send_byte(lw[w][8*b +: 8], mode);
          start = 1'b0;
        end
      end
      @(negedge clk);
      in_valid = 1'b0;
      wait_drain();
      $display("load n=%0d complete", n);
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
      check("err_set", 72'(err), 72'(1));
      check("hold_in_err", 72'(cpu_hold), 72'(1));
      $display("load n=%0d rejected", n);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err, 2'b00}, 72'(0));
    reset = 1'b1;

    lw[0] = 32'h01010303;
    run_load(1, 0, -1);

    lw[0] = 32'hAAAAAAAA;
    run_load(1, 0, -1);
    lw[0] = 32'h55555555;
    run_load(1, 0, -1);

    for (int i = 0; i < 8; i++) lw[i] = 32'(i);
    run_load(8, 1, -1);

    lw[0] = $urandom;
    lw[1] = $urandom;
    run_load(2, 0, 2);

    // Abort a load two data bytes in.
    do_start();
    send_byte(8'd2, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    check("reset_mid_load", {in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err, 2'b00}, 72'(0));
    reset = 1'b1;
    $display("reset mid-load applied");
    lw[0] = 32'hC0FFEE01;
    run_load(1, 0, -1);

    run_load(0, 0, -1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h01;
      check("err_hold_err", 72'(err), 72'(1));
      check("err_hold_cpu", 72'(cpu_hold), 72'(1));
      check("err_hold_ready", 72'(in_ready), 72'(0));
    end
    in_valid = 1'b0;
    run_load(9, 0, -1);
    lw[0] = 32'h0BADF00D;
    run_load(1, 0, -1);

    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(DEPTH, 1);
      for (int i = 0; i < n; i++) lw[i] = $urandom;
      run_load(n, 2, -1);
    end

    repeat (10) @(negedge clk);
    check("scoreboard_empty", 72'(exp_q.size() + exp_done), 72'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
